dclk_tick_counter: RTL and testbench
====================================

Name: dclk_tick_counter

Overview:
- Downstream consumer of the divided clock `Dclk` produced by the clock divider.
- Runs entirely in the `clk` domain. Samples `Dclk`, detects its rising edges as one-cycle ticks, and counts ticks in two-digit BCD (00..MAX).
- Start/stop/clear control.
- `END` pulses when the count reaches terminal and rolls over (or stops); it feeds the divider's `END` input and any display logic.

Parameters:
- MAX_TENS, 5, tens digit of terminal count (0..9)
- MAX_ONES, 9, ones digit of terminal count (0..9); terminal = MAX_TENS:MAX_ONES (default 59)
- WRAP, 1, 1 = roll over to 00 after terminal and keep running; 0 = stop at terminal in DONE

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- Dclk  input  1  divided clock from clock divider; same-domain register output, no synchroniser
- START  input  1  start/resume request, level sampled each clk
- STOP  input  1  pause request, level sampled each clk
- CLEAR  input  1  synchronous clear to 00/IDLE
- ONES  output  4  BCD ones digit
- TENS  output  4  BCD tens digit
- RUNNING  output  1  high while state == RUN
- END  output  1  one-clk pulse on terminal event

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE
  - ONES = 0, TENS = 0, RUNNING = 0, END = 0
  - edge register dclk_q = 0
- Edge detect:
  - dclk_q <= Dclk every clk.
  - tick = Dclk & ~dclk_q, combinational.
  - One tick per Dclk rising edge: every 4 clk with the divider's default divide-by-4.
- States: IDLE, RUN, PAUSED, DONE. Control priority: CLEAR > STOP > START.
- CLEAR, any state:
  - next state = IDLE, count = 00, END = 0.
  - A tick in the same cycle is discarded.
- IDLE:
  - START -> RUN.
  - A tick in the same cycle as START is not counted.
- RUN:
  - STOP -> PAUSED; a tick in the same cycle is not counted.
  - Otherwise, on tick, increment the count:
    - ONES == 9: ONES -> 0, TENS + 1.
    - Count == terminal and WRAP = 1: count -> 00, END = 1 for one clk, stay RUN.
    - Count == terminal and WRAP = 0: count held at terminal, END = 1 for one clk, -> DONE.
- PAUSED:
  - Count frozen, ticks ignored.
  - START -> RUN.
  - START and STOP together -> stay PAUSED (STOP wins).
- DONE:
  - Count holds terminal, ticks ignored.
  - START ignored; only CLEAR or reset leaves DONE.
- Latency:
  - Dclk rises on edge k; tick is high during cycle k.
  - ONES/TENS/END update on edge k+1.
  - RUNNING changes on the edge after START/STOP is sampled.
- END:
  - Registered; high exactly one clk per terminal event, never two consecutive cycles.
  - Low in all other states.
- Width rules:
  - Digits never leave 0..9.
  - A count above terminal (unreachable) is treated as terminal on the next tick.
- Reset mid-operation: async clear regardless of state or tick.
- Dclk held constant: no ticks, so the count never changes.

Test Plan:
- Reset then START, Dclk toggling every 2 clk -> RUNNING = 1 next clk; after 10 ticks, TENS = 1 and ONES = 0; each increment lands 1 clk after a Dclk rise.
- WRAP = 1, run 60 ticks from 00 -> at tick 60 the count goes 59 -> 00, END high exactly 1 clk, RUNNING stays 1; tick 61 gives 01.
- WRAP = 0, run 59 ticks and then 5 more ticks plus START -> count holds 59 in DONE, END pulsed once only; CLEAR then returns 00/IDLE.
- At count 07, assert STOP coincident with a tick -> count stays 07 and state is PAUSED; 3 further ticks give no change; START then 1 tick gives 08.
- START and CLEAR asserted together at count 23 -> count 00, IDLE, RUNNING = 0; START together with STOP from PAUSED -> stays PAUSED.
- Drop rst_n asynchronously mid-clock at count 42 in RUN -> outputs 0 immediately; after release with Dclk already high, no tick counted until the next Dclk rise following START.

Source files
------------

// File: rtl/dclk_tick_counter.sv
// rtl/dclk_tick_counter.sv - Dclk rising-edge tick counter, two-digit BCD with start/stop/clear control
module dclk_tick_counter #(
    parameter int unsigned MAX_TENS = 5,
    parameter int unsigned MAX_ONES = 9,
    parameter bit          WRAP     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Dclk,
    input  logic       START,
    input  logic       STOP,
    input  logic       CLEAR,
    output logic [3:0] ONES,
    output logic [3:0] TENS,
    output logic       RUNNING,
    output logic       END
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    localparam logic [3:0] TERM_TENS = 4'(MAX_TENS);
    localparam logic [3:0] TERM_ONES = 4'(MAX_ONES);

    state_t     state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       end_q, end_d;
    logic       dclk_q;
    logic       tick;
    logic       at_term;

    assign tick    = Dclk & ~dclk_q;
    // Anything at or above terminal (including unreachable values) takes the terminal path.
    assign at_term = (tens_q > TERM_TENS) || ((tens_q == TERM_TENS) && (ones_q >= TERM_ONES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            end_q   <= 1'b0;
            dclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            end_q   <= end_d;
            dclk_q  <= Dclk;
        end
    end

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        end_d   = 1'b0;
        if (CLEAR) begin
            state_d = IDLE;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (START && !STOP) state_d = RUN;
                end
                RUN: begin
                    if (STOP) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        if (at_term) begin
                            end_d = 1'b1;
                            if (WRAP) begin
                                ones_d = 4'd0;
                                tens_d = 4'd0;
                            end else begin
                                ones_d  = TERM_ONES;
                                tens_d  = TERM_TENS;
                                state_d = DONE;
                            end
                        end else if (ones_q >= 4'd9) begin
                            ones_d = 4'd0;
                            tens_d = tens_q + 4'd1;
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (START && !STOP) state_d = RUN;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ONES    = ones_q;
    assign TENS    = tens_q;
    assign RUNNING = (state_q == RUN);
    assign END     = end_q;
endmodule

// File: tb/tb_dclk_tick_counter.sv
// tb/tb_dclk_tick_counter.sv - self-checking bench for dclk_tick_counter (WRAP=1 and WRAP=0 instances)
module tb_dclk_tick_counter;
    localparam int TERM = 59;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Dclk, START, STOP, CLEAR;
    logic [3:0] ones_o [2];
    logic [3:0] tens_o [2];
    logic       run_o  [2];
    logic       end_o  [2];

    dclk_tick_counter #(.MAX_TENS(5), .MAX_ONES(9), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .Dclk(Dclk), .START(START), .STOP(STOP), .CLEAR(CLEAR),
        .ONES(ones_o[0]), .TENS(tens_o[0]), .RUNNING(run_o[0]), .END(end_o[0])
    );

    dclk_tick_counter #(.MAX_TENS(5), .MAX_ONES(9), .WRAP(1'b0)) dut_stop (
        .clk(clk), .rst_n(rst_n), .Dclk(Dclk), .START(START), .STOP(STOP), .CLEAR(CLEAR),
        .ONES(ones_o[1]), .TENS(tens_o[1]), .RUNNING(run_o[1]), .END(end_o[1])
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: count as a plain integer, mode 0=idle 1=run 2=paused 3=done
    int m_cnt [2];
    int m_st  [2];
    bit m_end [2];
    bit m_prev;
    int end_seen [2];

    typedef struct {
        bit start, stop, clear, dclk;
        int ones, tens;
        bit run, endp;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0d expected=%0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_st[i]  = 0;
            m_end[i] = 0;
        end
        m_prev = 0;
    endtask

    task automatic model_clock();
        bit tick;
        tick   = Dclk && !m_prev;
        m_prev = Dclk;
        for (int i = 0; i < 2; i++) begin
            m_end[i] = 0;
            if (CLEAR) begin
                m_st[i]  = 0;
                m_cnt[i] = 0;
            end else begin
                case (m_st[i])
                    0, 2: if (START && !STOP) m_st[i] = 1;
                    1: begin
                        if (STOP) m_st[i] = 2;
                        else if (tick) begin
                            if (m_cnt[i] >= TERM) begin
                                m_end[i] = 1;
                                if (i == 0) m_cnt[i] = 0;
                                else m_st[i] = 3;
                            end else begin
                                m_cnt[i] = m_cnt[i] + 1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            chk("ONES", i, int'(ones_o[i]), m_cnt[i] % 10);
            chk("TENS", i, int'(tens_o[i]), m_cnt[i] / 10);
            chk("RUNNING", i, int'(run_o[i]), (m_st[i] == 1) ? 1 : 0);
            chk("END", i, int'(end_o[i]), int'(m_end[i]));
            if (end_o[i]) end_seen[i]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_model();
    endtask

    task automatic set_in(input bit s, input bit p, input bit c, input bit d);
        START = s; STOP = p; CLEAR = c; Dclk = d;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            Dclk = 1'b0; step(); step();
            Dclk = 1'b1; step(); step();
        end
    endtask

    task automatic chk_count(input string name, input int idx, input int exp);
        chk(name, idx, int'(tens_o[idx]) * 10 + int'(ones_o[idx]), exp);
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 0};
        tbl[1]  = '{0, 0, 0, 1, 1, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 1, 1, 0, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 1, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 1, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 1, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 1, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 1, 2, 0, 1, 0};
        tbl[10] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 1, 0, 0, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[13] = '{0, 0, 0, 1, 1, 0, 1, 0};

        end_seen[0] = 0; end_seen[1] = 0;
        rst_n = 1'b0;
        set_in(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst_n = 1'b1;

        // Short directed table from reset
        foreach (tbl[k]) begin
            set_in(tbl[k].start, tbl[k].stop, tbl[k].clear, tbl[k].dclk);
            step();
            chk("tbl_ones", k, int'(ones_o[0]), tbl[k].ones);
            chk("tbl_tens", k, int'(tens_o[0]), tbl[k].tens);
            chk("tbl_run",  k, int'(run_o[0]),  int'(tbl[k].run));
            chk("tbl_end",  k, int'(end_o[0]),  int'(tbl[k].endp));
        end

        // Count to 07, STOP with a coincident tick, ignored ticks, resume to 08
        set_in(0, 0, 1, 0); step();
        set_in(1, 0, 0, 0); step();
        chk("start_run", 0, int'(run_o[0]), 1);
        START = 0;
        run_ticks(7);
        chk_count("cnt07", 0, 7);
        Dclk = 0; step(); step();
        STOP = 1; Dclk = 1; step();
        STOP = 0;
        chk_count("stop_tick", 0, 7);
        chk("paused_run", 0, int'(run_o[0]), 0);
        run_ticks(3);
        chk_count("paused_hold", 0, 7);
        START = 1; step(); START = 0;
        run_ticks(1);
        chk_count("resume08", 0, 8);
        run_ticks(2);
        chk_count("cnt10", 0, 10);
        run_ticks(13);
        chk_count("cnt23", 0, 23);
        START = 1; CLEAR = 1; step();
        START = 0; CLEAR = 0;
        chk_count("start_clear", 0, 0);
        chk("start_clear_run", 0, int'(run_o[0]), 0);

        // PAUSED with START+STOP stays paused
        START = 1; step(); START = 0;
        STOP = 1; step(); STOP = 0;
        START = 1; STOP = 1; step(); START = 0; STOP = 0;
        chk("paused_both", 0, int'(run_o[0]), 0);

        // Terminal behaviour for both WRAP settings
        set_in(0, 0, 1, 0); step();
        set_in(1, 0, 0, 0); step();
        START = 0;
        run_ticks(TERM);
        chk_count("at59", 0, 59);
        chk_count("at59", 1, 59);
        end_seen[0] = 0; end_seen[1] = 0;
        run_ticks(1);
        chk_count("wrap00", 0, 0);
        chk("wrap_run", 0, int'(run_o[0]), 1);
        chk_count("done59", 1, 59);
        chk("done_run", 1, int'(run_o[1]), 0);
        run_ticks(1);
        chk_count("wrap01", 0, 1);
        START = 1;
        run_ticks(4);
        START = 0;
        chk_count("done_hold", 1, 59);
        chk("end_once", 0, end_seen[0], 1);
        chk("end_once", 1, end_seen[1], 1);
        CLEAR = 1; step(); CLEAR = 0;
        chk_count("done_clear", 1, 0);

        // Async reset mid-clock at 42, then release with Dclk already high
        START = 1; step(); START = 0;
        run_ticks(42);
        chk_count("cnt42", 0, 42);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk_count("async_cnt", i, 0);
            chk("async_run", i, int'(run_o[i]), 0);
        end
        Dclk = 1;
        #2 rst_n = 1'b1;
        START = 1; step(); START = 0;
        step(); step();
        chk_count("no_stale_tick", 0, 0);
        Dclk = 0; step();
        Dclk = 1; step();
        chk_count("first_tick", 0, 1);

        // Randomised stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            CLEAR = ($urandom_range(0, 63) == 0);
            STOP  = ($urandom_range(0, 15) == 0);
            START = ($urandom_range(0, 3) == 0);
            Dclk  = $urandom_range(0, 1) == 1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
